// File: rtl/mapping_req_arbiter.sv
// Read/write request front end: per-stream FIFOs, credit-limited round-robin merge, hash bucket stage.
// Optional grant/stall statistics outputs are built when MAPPING_ARB_STATS_EN is defined.
module mapping_req_arbiter #(
   parameter int unsigned DATA_W          = 72,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned PAGE_SHIFT      = 12,
   parameter int unsigned HASH_BITS       = 16,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                               mc_ddr4_ui_clk,
   input  logic                               mc_ddr4_ui_clk_rst_n,
   input  logic [DATA_W-1:0]                  in_read_tdata,
   input  logic                               in_read_tvalid,
   output logic                               in_read_tready,
   input  logic [DATA_W-1:0]                  in_write_tdata,
   input  logic                               in_write_tvalid,
   output logic                               in_write_tready,
   output logic [DATA_W-1:0]                  out_req_tdata,
   output logic                               out_req_op,
   output logic [HASH_BITS-1:0]               out_req_bucket,
   output logic                               out_req_tvalid,
   input  logic                               out_req_tready,
   input  logic                               rsp_done,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
`ifdef MAPPING_ARB_STATS_EN
   output logic [31:0]                        stat_rd_grants,
   output logic [31:0]                        stat_wr_grants,
   output logic [31:0]                        stat_credit_stalls,
`endif
   output logic                               err_underflow
);

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned IDX_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W     = IDX_W + 1;
   localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned VPN_W     = ADDR_W - PAGE_SHIFT;
   localparam int unsigned N_CHUNK   = (VPN_W + HASH_BITS - 1) / HASH_BITS;
   localparam int unsigned VPN_EXT_W = N_CHUNK * HASH_BITS;

   // Fold the VPN chunks and the PID into one bucket index.
   function automatic logic [HASH_BITS-1:0] bucket_f(input logic [DATA_W-1:0] w);
      logic [VPN_EXT_W-1:0] vpn;
      logic [HASH_BITS-1:0] h;
      vpn = VPN_EXT_W'(w[ADDR_W-1:PAGE_SHIFT]);
      h   = HASH_BITS'(w[DATA_W-1:ADDR_W]);
      for (int unsigned i = 0; i < N_CHUNK; i++) begin
         h = h ^ vpn[i*HASH_BITS +: HASH_BITS];
      end
      return h;
   endfunction

   // Index 0 is the read stream, index 1 the write stream.
   logic [DATA_W-1:0] in_data [2];
   logic [1:0]        in_valid;
   logic [DATA_W-1:0] mem_q   [2][FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr_q  [2];
   logic [PTR_W-1:0]  wptr_d  [2];
   logic [PTR_W-1:0]  rptr_q  [2];
   logic [PTR_W-1:0]  rptr_d  [2];
   logic [1:0]        rdy_q, rdy_d;
   logic [1:0]        push, pop, ne;

   logic              last_q, last_d;
   logic              a_vld_q, a_vld_d, a_op_q, a_op_d;
   logic [DATA_W-1:0] a_data_q, a_data_d;
   logic              b_vld_q, b_vld_d, b_op_q, b_op_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic [HASH_BITS-1:0] b_bkt_q, b_bkt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic b_free, a_free, b_load, credit_ok, grant, gnt_op;

   assign in_data[0] = in_read_tdata;
   assign in_data[1] = in_write_tdata;
   assign in_valid   = {in_write_tvalid, in_read_tvalid};

   // FIFO pointers, ready (registered as !full of the next state) and arbitration.
   always_comb begin
      b_free    = !b_vld_q || out_req_tready;
      a_free    = !a_vld_q || b_free;
      b_load    = a_vld_q && b_free;
      credit_ok = cnt_q < CNT_W'(MAX_OUTSTANDING);
      for (int s = 0; s < 2; s++) begin
         ne[s] = wptr_q[s] != rptr_q[s];
      end
      gnt_op = (ne[0] && ne[1]) ? !last_q : ne[1];
      grant  = (|ne) && a_free && credit_ok;
      pop    = grant ? (gnt_op ? 2'b10 : 2'b01) : 2'b00;
      push   = in_valid & rdy_q;
      last_d = grant ? gnt_op : last_q;
      for (int s = 0; s < 2; s++) begin
         wptr_d[s] = wptr_q[s] + PTR_W'(push[s]);
         rptr_d[s] = rptr_q[s] + PTR_W'(pop[s]);
         rdy_d[s]  = (wptr_d[s] - rptr_d[s]) != PTR_W'(FIFO_DEPTH);
      end
   end

   // Two-stage pipeline with bubble collapsing; hash sits between A and B.
   always_comb begin
      a_vld_d  = grant || (a_vld_q && !b_free);
      a_op_d   = grant ? gnt_op : a_op_q;
      a_data_d = grant ? mem_q[gnt_op][rptr_q[gnt_op][IDX_W-1:0]] : a_data_q;
      b_vld_d  = b_load || (b_vld_q && !out_req_tready);
      b_op_d   = b_load ? a_op_q : b_op_q;
      b_data_d = b_load ? a_data_q : b_data_q;
      b_bkt_d  = b_load ? bucket_f(a_data_q) : b_bkt_q;
   end

   // Credit counter; a retire with nothing outstanding is flagged and ignored.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      unique case ({grant, rsp_done})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (rsp_done && cnt_q == '0) err_d = 1'b1;
   end

   always_ff @(posedge mc_ddr4_ui_clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) mem_q[s][wptr_q[s][IDX_W-1:0]] <= in_data[s];
      end
   end

   always_ff @(posedge mc_ddr4_ui_clk or negedge mc_ddr4_ui_clk_rst_n) begin
      if (!mc_ddr4_ui_clk_rst_n) begin
         for (int s = 0; s < 2; s++) begin
            wptr_q[s] <= '0;
            rptr_q[s] <= '0;
         end
         rdy_q    <= '0;
         last_q   <= 1'b1;
         a_vld_q  <= 1'b0;
         a_op_q   <= 1'b0;
         a_data_q <= '0;
         b_vld_q  <= 1'b0;
         b_op_q   <= 1'b0;
         b_data_q <= '0;
         b_bkt_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            wptr_q[s] <= wptr_d[s];
            rptr_q[s] <= rptr_d[s];
         end
         rdy_q    <= rdy_d;
         last_q   <= last_d;
         a_vld_q  <= a_vld_d;
         a_op_q   <= a_op_d;
         a_data_q <= a_data_d;
         b_vld_q  <= b_vld_d;
         b_op_q   <= b_op_d;
         b_data_q <= b_data_d;
         b_bkt_q  <= b_bkt_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign in_read_tready  = rdy_q[0];
   assign in_write_tready = rdy_q[1];
   assign out_req_tvalid  = b_vld_q;
   assign out_req_op      = b_op_q;
   assign out_req_tdata   = b_data_q;
   assign out_req_bucket  = b_bkt_q;
   assign outstanding     = cnt_q;
   assign err_underflow   = err_q;

`ifdef MAPPING_ARB_STATS_EN
   logic [31:0] st_rd_q, st_rd_d, st_wr_q, st_wr_d, st_stall_q, st_stall_d;

   always_comb begin
      st_rd_d    = st_rd_q + 32'(pop[0]);
      st_wr_d    = st_wr_q + 32'(pop[1]);
      st_stall_d = st_stall_q + 32'((|ne) && !credit_ok);
   end

   always_ff @(posedge mc_ddr4_ui_clk or negedge mc_ddr4_ui_clk_rst_n) begin
      if (!mc_ddr4_ui_clk_rst_n) begin
         st_rd_q    <= '0;
         st_wr_q    <= '0;
         st_stall_q <= '0;
      end else begin
         st_rd_q    <= st_rd_d;
         st_wr_q    <= st_wr_d;
         st_stall_q <= st_stall_d;
      end
   end

   assign stat_rd_grants     = st_rd_q;
   assign stat_wr_grants     = st_wr_q;
   assign stat_credit_stalls = st_stall_q;
`endif

endmodule

// File: tb/tb_mapping_req_arbiter.sv
// Self-checking bench for mapping_req_arbiter: per-stream scoreboard plus scenario tasks.
module tb_mapping_req_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [71:0] rd_data = '0, wr_data = '0;
   logic        rd_valid = 1'b0, wr_valid = 1'b0;
   logic        in_read_tready, in_write_tready;
   logic [71:0] out_req_tdata;
   logic        out_req_op;
   logic [15:0] out_req_bucket;
   logic        out_req_tvalid;
   logic        out_ready = 1'b0;
   logic        rsp_done = 1'b0;
   logic [3:0]  outstanding;
   logic        err_underflow;
`ifdef MAPPING_ARB_STATS_EN
   logic [31:0] stat_rd_grants, stat_wr_grants, stat_credit_stalls;
`endif

   int errors = 0;
   int checks = 0;
   int out_cnt = 0;
   logic [71:0] exp_rd [$];
   logic [71:0] exp_wr [$];
   logic        op_log [$];

   always #5 clk = ~clk;

   mapping_req_arbiter dut (
      .mc_ddr4_ui_clk       (clk),
      .mc_ddr4_ui_clk_rst_n (rst_n),
      .in_read_tdata        (rd_data),
      .in_read_tvalid       (rd_valid),
      .in_read_tready       (in_read_tready),
      .in_write_tdata       (wr_data),
      .in_write_tvalid      (wr_valid),
      .in_write_tready      (in_write_tready),
      .out_req_tdata        (out_req_tdata),
      .out_req_op           (out_req_op),
      .out_req_bucket       (out_req_bucket),
      .out_req_tvalid       (out_req_tvalid),
      .out_req_tready       (out_ready),
      .rsp_done             (rsp_done),
      .outstanding          (outstanding),
`ifdef MAPPING_ARB_STATS_EN
      .stat_rd_grants       (stat_rd_grants),
      .stat_wr_grants       (stat_wr_grants),
      .stat_credit_stalls   (stat_credit_stalls),
`endif
      .err_underflow        (err_underflow)
   );

   function automatic logic [15:0] model_bucket(input logic [71:0] w);
      logic [63:0] v;
      v = w[63:0] >> 12;
      return v[15:0] ^ v[31:16] ^ v[47:32] ^ v[63:48] ^ {8'h00, w[71:64]};
   endfunction

   // Output monitor: every accepted output is matched against its stream's queue.
   always @(negedge clk) begin
      if (rst_n && out_req_tvalid && out_ready) begin
         logic [71:0] e;
         out_cnt++;
         op_log.push_back(out_req_op);
         checks++;
         if ((out_req_op && exp_wr.size() == 0) || (!out_req_op && exp_rd.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_output op=%0d data=%h", out_req_op, out_req_tdata);
         end else begin
            e = out_req_op ? exp_wr.pop_front() : exp_rd.pop_front();
            if (out_req_tdata !== e || out_req_bucket !== model_bucket(e)) begin
               errors++;
               $display("FAIL out_word op=%0d got data=%h bucket=%h, want data=%h bucket=%h",
                        out_req_op, out_req_tdata, out_req_bucket, e, model_bucket(e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      out_ready = 1'b0;
      rsp_done = 1'b0;
      exp_rd.delete();
      exp_wr.delete();
      op_log.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Offer one word on a stream; waits (bounded) for the handshake and records the expectation.
   task automatic send(input bit s, input logic [71:0] d, output bit ok);
      ok = 1'b0;
      if (s) begin wr_data = d; wr_valid = 1'b1; end
      else   begin rd_data = d; rd_valid = 1'b1; end
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = s ? in_write_tready : in_read_tready;
         @(posedge clk);
         #1;
      end
      if (s) wr_valid = 1'b0; else rd_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout stream=%0d accepted=0 want 1", s);
      end else if (s) exp_wr.push_back(d);
      else exp_rd.push_back(d);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({in_read_tready, in_write_tready, out_req_tvalid, out_req_op, err_underflow} !== 5'b0 ||
          outstanding !== 4'd0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b%b vld=%b op=%b err=%b outst=%0d want all 0",
                  in_read_tready, in_write_tready, out_req_tvalid, out_req_op, err_underflow, outstanding);
      end
      checks++;
      if (out_req_tdata !== 72'd0 || out_req_bucket !== 16'd0) begin
         errors++;
         $display("FAIL reset_data got data=%h bucket=%h want 0", out_req_tdata, out_req_bucket);
      end
      do_reset();
      checks++;
      if ({in_read_tready, in_write_tready} !== 2'b11) begin
         errors++;
         $display("FAIL ready_after_reset got %b%b want 11", in_read_tready, in_write_tready);
      end
   endtask

   task automatic test_latency();
      logic [71:0] d;
      logic v1, v2, v3, op3;
      logic [15:0] bk3;
      logic [71:0] dat3;
      d = {8'h00, 64'h0000_0000_1234_5000};
      do_reset();
      out_ready = 1'b1;
      rd_data = d;
      rd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_read_tready !== 1'b1) begin
         errors++;
         $display("FAIL lat_ready got %b want 1", in_read_tready);
      end
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      exp_rd.push_back(d);
      @(negedge clk); v1 = out_req_tvalid;
      @(negedge clk); v2 = out_req_tvalid;
      @(negedge clk); v3 = out_req_tvalid; op3 = out_req_op; bk3 = out_req_bucket; dat3 = out_req_tdata;
      checks++;
      if ({v1, v2, v3} !== 3'b001) begin
         errors++;
         $display("FAIL lat_valid got cycles1..3=%b%b%b want 001", v1, v2, v3);
      end
      checks++;
      if (op3 !== 1'b0 || bk3 !== 16'h2344 || dat3 !== d) begin
         errors++;
         $display("FAIL lat_word got op=%b bucket=%h data=%h want op=0 bucket=2344 data=%h", op3, bk3, dat3, d);
      end
      tick();
      checks++;
      if (outstanding !== 4'd1) begin
         errors++;
         $display("FAIL lat_outstanding got %0d want 1", outstanding);
      end
   endtask

   task automatic test_pid_fold();
      bit ok, seen;
      logic op;
      logic [15:0] bk;
      seen = 1'b0;
      op = 1'b0;
      bk = '0;
      send(1'b1, {8'h01, 64'h0000_0000_1234_5000}, ok);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (out_req_tvalid) begin seen = 1'b1; op = out_req_op; bk = out_req_bucket; end
      end
      checks++;
      if (!seen || op !== 1'b1 || bk !== 16'h2345) begin
         errors++;
         $display("FAIL pid_fold got seen=%b op=%b bucket=%h want seen=1 op=1 bucket=2345", seen, op, bk);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [5:0] seq;
      int w;
      do_reset();
      out_ready = 1'b1;
      rd_valid = 1'b1;
      wr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rd_data = {8'h10 + 8'(k), 64'h0000_00AA_0000_1000 + 64'(k) * 64'h1000};
         wr_data = {8'h20 + 8'(k), 64'h0000_00BB_0000_7000 + 64'(k) * 64'h1000};
         @(negedge clk);
         checks++;
         if ({in_read_tready, in_write_tready} !== 2'b11) begin
            errors++;
            $display("FAIL rr_ready k=%0d got %b%b want 11", k, in_read_tready, in_write_tready);
         end
         @(posedge clk);
         #1;
         exp_rd.push_back(rd_data);
         exp_wr.push_back(wr_data);
      end
      rd_valid = 1'b0;
      wr_valid = 1'b0;
      w = 0;
      while (op_log.size() < 6 && w < 30) begin tick(); w++; end
      checks++;
      if (op_log.size() != 6) begin
         errors++;
         $display("FAIL rr_count got %0d want 6", op_log.size());
      end else begin
         seq = {op_log[0], op_log[1], op_log[2], op_log[3], op_log[4], op_log[5]};
         checks++;
         if (seq !== 6'b010101) begin
            errors++;
            $display("FAIL rr_order got %b want 010101", seq);
         end
      end
   endtask

   task automatic test_credit_limit();
      bit ok;
      int base;
      do_reset();
      out_ready = 1'b1;
      base = out_cnt;
      for (int i = 0; i < 10; i++) send(1'b0, {8'h05, 64'h0000_0001_0000_0000 + 64'(i) * 64'h3000}, ok);
      repeat (15) tick();
      checks++;
      if (out_cnt - base != 8 || outstanding !== 4'd8 || out_req_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL credit_stall got outputs=%0d outst=%0d vld=%b want 8 8 0",
                  out_cnt - base, outstanding, out_req_tvalid);
      end
      checks++;
      if (exp_rd.size() != 2) begin
         errors++;
         $display("FAIL credit_held got %0d pending want 2", exp_rd.size());
      end
      rsp_done = 1'b1;
      tick();
      rsp_done = 1'b0;
      repeat (10) tick();
      checks++;
      if (out_cnt - base != 9 || outstanding !== 4'd8) begin
         errors++;
         $display("FAIL credit_release got outputs=%0d outst=%0d want 9 8", out_cnt - base, outstanding);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int base, acc;
      do_reset();
      out_ready = 1'b0;
      base = out_cnt;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, {8'h30 + 8'(i), 64'h0000_0ABC_DE00_0000 + 64'(i) * 64'h1000}, ok);
         if (ok) acc++;
      end
      @(negedge clk);
      checks++;
      if (acc != 6 || in_write_tready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full got accepted=%0d ready=%b want 6 0", acc, in_write_tready);
      end
      checks++;
      if (out_req_tvalid !== 1'b1 || outstanding !== 4'd2 || out_cnt != base) begin
         errors++;
         $display("FAIL bp_hold got vld=%b outst=%0d outputs=%0d want 1 2 0",
                  out_req_tvalid, outstanding, out_cnt - base);
      end
      tick();
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      tick();
      checks++;
      if (out_cnt - base != 6 || out_req_tvalid !== 1'b0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL bp_drain got outputs=%0d vld=%b pending=%0d want 6 0 0",
                  out_cnt - base, out_req_tvalid, exp_wr.size());
      end
   endtask

   task automatic test_underflow();
      do_reset();
      rsp_done = 1'b1;
      tick();
      rsp_done = 1'b0;
      tick();
      checks++;
      if (err_underflow !== 1'b1 || outstanding !== 4'd0) begin
         errors++;
         $display("FAIL underflow got err=%b outst=%0d want 1 0", err_underflow, outstanding);
      end
      repeat (3) tick();
      checks++;
      if (err_underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_sticky got %b want 1", err_underflow);
      end
   endtask

   task automatic test_reset_midstream();
      bit ok;
      int base;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b1, {8'h44, 64'h0000_0000_0F00_0000 + 64'(i) * 64'h1000}, ok);
      base = out_cnt;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_read_tready, in_write_tready, out_req_tvalid, err_underflow} !== 4'b0 ||
          outstanding !== 4'd0 || out_req_tdata !== 72'd0) begin
         errors++;
         $display("FAIL midreset got rdy=%b%b vld=%b err=%b outst=%0d data=%h want all 0",
                  in_read_tready, in_write_tready, out_req_tvalid, err_underflow, outstanding, out_req_tdata);
      end
      exp_rd.delete();
      exp_wr.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (10) tick();
      checks++;
      if (out_cnt != base || out_req_tvalid !== 1'b0 || {in_read_tready, in_write_tready} !== 2'b11) begin
         errors++;
         $display("FAIL no_stale got outputs=%0d vld=%b rdy=%b%b want 0 0 11",
                  out_cnt - base, out_req_tvalid, in_read_tready, in_write_tready);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_pid_fold();
      test_round_robin();
      test_credit_limit();
      test_backpressure();
      test_underflow();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mapping_req_arbiter.md
Name: mapping_req_arbiter

Overview:
Upstream front end of the hashed-paging mapping core. It accepts independent read and write request streams, each a 72-bit word with the virtual address in [63:0] and the PID in [71:64]. It buffers each stream, merges them with round-robin arbitration under an outstanding-request credit limit, and computes the hash bucket index. It delivers a single tagged request stream to the DRAM lookup stage.

Parameters:
DATA_W, 72, request word width; address in [63:0], PID in [71:64]
FIFO_DEPTH, 4, per-input buffer depth; power of 2, at least 2
PAGE_SHIFT, 12, page offset bits dropped before hashing
HASH_BITS, 16, bucket index width
MAX_OUTSTANDING, 8, maximum requests granted but not yet completed

Ports:
mc_ddr4_ui_clk  in  1  single clock
mc_ddr4_ui_clk_rst_n  in  1  asynchronous active-low reset
in_read_tdata  in  DATA_W  read request
in_read_tvalid  in  1  read request valid
in_read_tready  out  1  read request ready
in_write_tdata  in  DATA_W  write request
in_write_tvalid  in  1  write request valid
in_write_tready  out  1  write request ready
out_req_tdata  out  DATA_W  request word, passed through unchanged
out_req_op  out  1  0 = read, 1 = write
out_req_bucket  out  HASH_BITS  hash bucket index
out_req_tvalid  out  1  output valid
out_req_tready  in  1  output ready
rsp_done  in  1  one-cycle pulse from downstream; one request retired
outstanding  out  log2(MAX_OUTSTANDING)+1  current credit count
err_underflow  out  1  sticky; set by rsp_done while outstanding == 0

Behaviour:
- Reset: one clock, mc_ddr4_ui_clk; reset mc_ddr4_ui_clk_rst_n is asynchronous, active-low.
  - While asserted: all outputs 0, FIFOs and pipeline emptied, last_grant = write, so read wins the first tie.
  - Reset asserted mid-operation discards all in-flight requests; no partial output is produced.
- Input FIFOs (one per stream):
  - tready = !full; write on tvalid && tready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full: tready low and no write that cycle, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO is allowed; occupancy is unchanged.
- Arbiter (combinational grant, registered last_grant):
  - Eligible when: FIFO non-empty && stage A can load && outstanding < MAX_OUTSTANDING.
  - Credit stall: at outstanding == MAX_OUTSTANDING there is no grant, even if rsp_done pulses that cycle.
  - Both streams non-empty: grant the stream opposite to last_grant. Only one non-empty: grant it.
  - A grant pops that FIFO, loads stage A with {op, data} and updates last_grant.
- Credit counter:
  - +1 on grant, -1 on rsp_done; both in the same cycle leave it unchanged.
  - rsp_done at 0 leaves the count at 0 and sets err_underflow, which clears only on reset.
- Pipeline: stage A holds {op, data}; stage B holds {op, data, bucket}. Stage B drives the out_req_* signals.
  - A stage loads when it is empty or its successor is advancing (bubble collapsing).
  - Stage B holds its contents while out_req_tvalid && !out_req_tready.
  - Full throughput: one request per cycle when out_req_tready stays high.
- Latency: input handshake at edge N gives out_req_tvalid in cycle N+3 when the pipeline is empty and credit is available.
- Hash (computed between stage A and stage B):
  - vpn = addr[63:PAGE_SHIFT], zero-extended to a multiple of HASH_BITS.
  - bucket = XOR of all HASH_BITS-wide chunks of vpn, XOR {zero-extended PID}, truncated to HASH_BITS.
- Ordering: requests from the same stream leave in arrival order. Order between the read and write streams is set only by arbitration.

Optional Feature:
MAPPING_ARB_STATS_EN
- Defined: adds outputs stat_rd_grants[31:0], stat_wr_grants[31:0] and stat_credit_stalls[31:0].
  - The grant counters increment on each grant of their stream.
  - The stall counter increments each cycle where some FIFO is non-empty but the credit limit blocks a grant.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Read-only latency: single read, addr 0x0000_0000_1234_5000, PID 0x00, out_req_tready=1. Required: out_req_tvalid exactly 3 cycles after the input handshake, op=0, bucket=0x2344, data unchanged.
- PID fold: same address, PID 0x01, sent on the write stream. Required: op=1, bucket=0x2345.
- Round-robin: both FIFOs preloaded with 3 requests each, first grant after reset. Required output op sequence 0,1,0,1,0,1.
- Credit limit: 10 reads, rsp_done never pulsed. Required: exactly 8 outputs, outstanding=8, remaining 2 held. After one rsp_done pulse, exactly one more output appears.
- Backpressure and full: out_req_tready=0, 6 writes offered. Required: 1 request in stage B, 1 in stage A, 4 in the FIFO. in_write_tready goes low after the 6th accept. Releasing ready drains all 6 in order, one per cycle.
- Error and reset: rsp_done pulsed at outstanding=0 gives err_underflow=1 and outstanding stays 0. Reset asserted mid-stream: all outputs 0 immediately, and no stale request appears after release.
